// File: rtl/ps2_scancode_fifo_rx.sv
// rtl/ps2_scancode_fifo_rx.sv - PS/2 keyboard receiver with glitch filter, prefix decoding and event FIFO
//
// Receives 11-bit PS/2 frames from the raw pins. It filters the clock pin, checks each frame,
// and decodes E0 (extended) and F0 (break) prefixes. Each completed key event is queued in a
// first-word-fall-through FIFO.
//
// Ports:
//   CLK, RST_N     system clock (rising edge) and asynchronous active-low reset
//   PS2_CLK        raw PS/2 clock pin (asynchronous)
//   PS2_DATA       raw PS/2 data pin (asynchronous)
//   KEY_READY      consumer accepts the head entry (pops when KEY_VALID is also 1)
//   CLR_OVF        single-cycle pulse that clears OVERFLOW
//   KEY_VALID      FIFO not empty; the head entry is shown on KEY_CODE/KEY_BREAK/KEY_EXTENDED
//   KEY_CODE       scan code of the head entry (0 when empty)
//   KEY_BREAK      head entry is a release (0 when empty)
//   KEY_EXTENDED   head entry is extended (0 when empty)
//   FIFO_COUNT     number of stored entries
//   FRAME_ERROR    single-cycle pulse on a bad or timed-out frame
//   OVERFLOW       sticky flag; an event was dropped because the FIFO was full
module ps2_scancode_fifo_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          PS2_CLK,
  input  logic                          PS2_DATA,
  input  logic                          KEY_READY,
  input  logic                          CLR_OVF,
  output logic                          KEY_VALID,
  output logic [7:0]                    KEY_CODE,
  output logic                          KEY_BREAK,
  output logic                          KEY_EXTENDED,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
  output logic                          FRAME_ERROR,
  output logic                          OVERFLOW
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // ---------------------------------------------------------------- input path
  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          fall;      // one cycle after the filtered clock drops
  logic          bit_s;     // data level captured with that drop

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], PS2_CLK};
      data_sync <= {data_sync[0], PS2_DATA};
    end
  end

  // The filtered level only follows the synced clock once FILTER_LEN samples
  // in a row disagree with it. Any agreeing sample restarts the run.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
      bit_s    <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_sync[1] != filt_clk) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          filt_clk <= clk_sync[1];
          filt_cnt <= '0;
          if (filt_clk) begin
            fall  <= 1'b1;
            bit_s <= data_sync[1];
          end
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------- frame FSM
  typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK} state_t;

  state_t        state;
  logic [10:0]   shreg;     // [0]=start, [8:1]=data, [9]=parity, [10]=stop once full
  logic [3:0]    bitcnt;
  logic [TW-1:0] to_cnt;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          frame_ok;
  logic          timeout_hit;
  logic          err_now;

  assign frame_ok    = !shreg[0] && shreg[10] && (^shreg[9:1]);
  assign timeout_hit = (state == S_RECV) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign err_now     = ((state == S_CHECK) && !frame_ok) || timeout_hit;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      shreg       <= '0;
      bitcnt      <= '0;
      to_cnt      <= '0;
      FRAME_ERROR <= 1'b0;
      byte_valid  <= 1'b0;
      byte_data   <= '0;
    end else begin
      FRAME_ERROR <= 1'b0;
      byte_valid  <= 1'b0;
      case (state)
        S_IDLE: begin
          to_cnt <= '0;
          if (fall) begin
            shreg  <= {bit_s, shreg[10:1]};
            bitcnt <= 4'd1;
            state  <= S_RECV;
          end
        end
        S_RECV: begin
          if (fall) begin
            shreg  <= {bit_s, shreg[10:1]};
            to_cnt <= '0;
            if (bitcnt == 4'd10) begin
              state <= S_CHECK;
            end else begin
              bitcnt <= bitcnt + 4'd1;
            end
          end else if (timeout_hit) begin
            state       <= S_IDLE;
            to_cnt      <= '0;
            FRAME_ERROR <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          state <= S_IDLE;
          if (frame_ok) begin
            byte_valid <= 1'b1;
            byte_data  <= shreg[8:1];
          end else begin
            FRAME_ERROR <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- prefix decoder
  logic ext_flag;
  logic brk_flag;
  logic push_req;

  assign push_req = byte_valid && (byte_data != 8'hE0) && (byte_data != 8'hF0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (err_now) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (byte_valid) begin
      if (byte_data == 8'hE0) begin
        ext_flag <= 1'b1;
      end else if (byte_data == 8'hF0) begin
        brk_flag <= 1'b1;
      end else begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- event FIFO
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          do_pop;
  logic          do_push;
  logic [9:0]    head;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_pop  = KEY_VALID && KEY_READY;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push_req && (!full || do_pop);

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= {ext_flag, brk_flag, byte_data};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A new drop takes priority over a clear arriving in the same cycle.
      if (push_req && full && !do_pop) begin
        OVERFLOW <= 1'b1;
      end else if (CLR_OVF) begin
        OVERFLOW <= 1'b0;
      end
    end
  end

  assign head         = mem[rd_ptr];
  assign KEY_VALID    = (count != '0);
  assign KEY_CODE     = KEY_VALID ? head[7:0] : 8'h00;
  assign KEY_BREAK    = KEY_VALID ? head[8]   : 1'b0;
  assign KEY_EXTENDED = KEY_VALID ? head[9]   : 1'b0;
  assign FIFO_COUNT   = count;

endmodule

// File: tb/tb_ps2_scancode_fifo_rx.sv
// tb/tb_ps2_scancode_fifo_rx.sv - randomized self-checking bench for ps2_scancode_fifo_rx
module tb_ps2_scancode_fifo_rx;

  localparam int FILT    = 8;
  localparam int TMO     = 1000;
  localparam int DEPTH   = 8;
  // 2 synchroniser flops + FILT filter samples, then 3 cycles to KEY_VALID
  localparam int EXP_LAT = 2 + FILT + 3;

  logic                     CLK = 1'b0;
  logic                     RST_N = 1'b0;
  logic                     PS2_CLK = 1'b1;
  logic                     PS2_DATA = 1'b1;
  logic                     KEY_READY = 1'b0;
  logic                     CLR_OVF = 1'b0;
  logic                     KEY_VALID;
  logic [7:0]               KEY_CODE;
  logic                     KEY_BREAK;
  logic                     KEY_EXTENDED;
  logic [$clog2(DEPTH):0]   FIFO_COUNT;
  logic                     FRAME_ERROR;
  logic                     OVERFLOW;

  ps2_scancode_fifo_rx #(
    .FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .KEY_READY(KEY_READY), .CLR_OVF(CLR_OVF), .KEY_VALID(KEY_VALID),
    .KEY_CODE(KEY_CODE), .KEY_BREAK(KEY_BREAK), .KEY_EXTENDED(KEY_EXTENDED),
    .FIFO_COUNT(FIFO_COUNT), .FRAME_ERROR(FRAME_ERROR), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int err_seen = 0;
  int exp_err = 0;
  int last_lat = 0;
  logic [9:0] exp_q[$];   // {ext, brk, code}
  logic m_ext = 1'b0;
  logic m_brk = 1'b0;
  logic exp_ovf = 1'b0;

  always @(negedge CLK) if (FRAME_ERROR === 1'b1) err_seen++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] make_frame(input logic [7:0] d, input int kind);
    logic par, st, sp;
    par = ~^d;  // odd parity over data+parity
    st  = 1'b0;
    sp  = 1'b1;
    if (kind == 1) par = ~par;
    if (kind == 2) st = 1'b1;
    if (kind == 3) sp = 1'b0;
    return {sp, par, d, st};
  endfunction

  function automatic logic [7:0] rand_code();
    logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    if (d == 8'hE0 || d == 8'hF0) d = 8'h1C;
    return d;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    exp_ovf = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] d, input bit ok);
    if (!ok) begin
      exp_err++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (d == 8'hE0) begin
      m_ext = 1'b1;
    end else if (d == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, d});
      else exp_ovf = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // Drives nbits of a frame; on the last bit reports how many cycles after the pin fell
  // KEY_VALID was first seen, and optionally pulses KEY_READY at cycle pop_at.
  task automatic send_frame(input logic [10:0] bits, input int nbits, input int h,
                            input int pop_at, output int lat);
    lat = 0;
    for (int i = 0; i < nbits; i++) begin
      PS2_DATA = bits[i];
      repeat (h) @(negedge CLK);
      PS2_CLK = 1'b0;
      for (int k = 1; k <= h; k++) begin
        @(negedge CLK);
        if (i == nbits - 1) begin
          if (KEY_VALID === 1'b1 && lat == 0) lat = k;
          if (pop_at > 0 && k == pop_at) KEY_READY = 1'b1;
          else if (pop_at > 0 && k == pop_at + 1) KEY_READY = 1'b0;
        end
      end
      PS2_CLK = 1'b1;
    end
    repeat (h) @(negedge CLK);
    PS2_DATA = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input int kind, input int h, input int pop_at);
    int lat;
    send_frame(make_frame(d, kind), 11, h, pop_at, lat);
    last_lat = lat;
    if (pop_at > 0 && exp_q.size() > 0) void'(exp_q.pop_front());
    model_frame(d, kind == 0);
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 0;
    while (exp_q.size() > 0 && budget < 300) begin
      @(negedge CLK);
      budget++;
      checks++;
      if (KEY_VALID !== 1'b1 || {KEY_EXTENDED, KEY_BREAK, KEY_CODE} !== exp_q[0]) begin
        failures++;
        $display("FAIL %s_head: valid=%b ext/brk/code=%h expected valid=1 ext/brk/code=%h",
                 name, KEY_VALID, {KEY_EXTENDED, KEY_BREAK, KEY_CODE}, exp_q[0]);
      end
      if ($urandom_range(0, 1) == 1) begin
        KEY_READY = 1'b1;
        void'(exp_q.pop_front());
      end else begin
        KEY_READY = 1'b0;
      end
    end
    @(negedge CLK);
    KEY_READY = 1'b0;
    checks++;
    if (budget >= 300 || KEY_VALID !== 1'b0 || {KEY_EXTENDED, KEY_BREAK, KEY_CODE} !== 10'h0
        || FIFO_COUNT !== '0) begin
      failures++;
      $display("FAIL %s_empty: valid=%b outs=%h count=%0d budget=%0d expected valid=0 outs=0 count=0",
               name, KEY_VALID, {KEY_EXTENDED, KEY_BREAK, KEY_CODE}, FIFO_COUNT, budget);
    end
  endtask

  task automatic check_err(input string name);
    checks++;
    if (err_seen != exp_err) begin
      failures++;
      $display("FAIL %s_frame_error: pulses=%0d expected=%0d", name, err_seen, exp_err);
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    checks++;
    if ({KEY_VALID, KEY_CODE, KEY_BREAK, KEY_EXTENDED, FIFO_COUNT, FRAME_ERROR, OVERFLOW} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0",
               {KEY_VALID, KEY_CODE, KEY_BREAK, KEY_EXTENDED, FIFO_COUNT, FRAME_ERROR, OVERFLOW});
    end
    RST_N = 1'b1;
    repeat (20) @(negedge CLK);
    checks++;
    if (KEY_VALID !== 1'b0 || FIFO_COUNT !== '0 || OVERFLOW !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: valid=%b count=%0d ovf=%b expected 0 0 0",
               KEY_VALID, FIFO_COUNT, OVERFLOW);
    end
    check_err("reset");
  endtask

  task automatic test_make_code();
    send_byte(8'h1C, 0, 20, 0);
    checks++;
    if (last_lat != EXP_LAT) begin
      failures++;
      $display("FAIL make_latency: got %0d cycles expected %0d", last_lat, EXP_LAT);
    end
    checks++;
    if (FIFO_COUNT !== 1) begin
      failures++;
      $display("FAIL make_count: got %0d expected 1", FIFO_COUNT);
    end
    drain("make");
    check_err("make");
  endtask

  task automatic test_extended_release();
    send_byte(8'hE0, 0, 20, 0);
    send_byte(8'hF0, 0, 20, 0);
    send_byte(8'h75, 0, 20, 0);
    checks++;
    if (FIFO_COUNT !== 1 || exp_q.size() != 1 || exp_q[0] !== 10'h375) begin
      failures++;
      $display("FAIL ext_release_count: got %0d expected 1", FIFO_COUNT);
    end
    drain("ext_release");
    check_err("ext_release");
  endtask

  task automatic test_parity_error();
    send_byte(8'hE0, 0, 20, 0);
    send_byte(8'h29, 1, 20, 0);
    checks++;
    if (FIFO_COUNT !== 0) begin
      failures++;
      $display("FAIL parity_count: got %0d expected 0", FIFO_COUNT);
    end
    check_err("parity");
    send_byte(8'h29, 0, 20, 0);
    drain("parity_good");
  endtask

  task automatic test_timeout();
    int lat;
    send_frame(make_frame(8'h55, 0), 5, 20, 0, lat);
    repeat (TMO + 10) @(negedge CLK);
    model_frame(8'h00, 1'b0);
    check_err("timeout");
    send_byte(8'h72, 0, 20, 0);
    drain("timeout_next");
    check_err("timeout_next");
  endtask

  task automatic test_fifo();
    KEY_READY = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) send_byte(rand_code(), 0, 16, 0);
    checks++;
    if (FIFO_COUNT !== DEPTH || OVERFLOW !== exp_ovf || exp_ovf !== 1'b1) begin
      failures++;
      $display("FAIL fifo_full: count=%0d ovf=%b expected count=%0d ovf=1", FIFO_COUNT, OVERFLOW, DEPTH);
    end
    @(negedge CLK) CLR_OVF = 1'b1;
    @(negedge CLK) CLR_OVF = 1'b0;
    exp_ovf = 1'b0;
    checks++;
    if (OVERFLOW !== 1'b0) begin
      failures++;
      $display("FAIL clr_ovf: ovf=%b expected 0", OVERFLOW);
    end
    // Pop exactly on the push edge while full
    send_byte(rand_code(), 0, 20, EXP_LAT - 1);
    checks++;
    if (FIFO_COUNT !== DEPTH || OVERFLOW !== 1'b0) begin
      failures++;
      $display("FAIL full_push_pop: count=%0d ovf=%b expected count=%0d ovf=0", FIFO_COUNT, OVERFLOW, DEPTH);
    end
    drain("fifo");
    check_err("fifo");
  endtask

  task automatic test_glitch();
    @(negedge CLK) PS2_CLK = 1'b0;
    repeat (FILT - 2) @(negedge CLK);
    PS2_CLK = 1'b1;
    repeat (30) @(negedge CLK);
    send_byte(8'h4B, 0, 18, 0);
    drain("glitch");
    check_err("glitch");
  endtask

  task automatic test_reset_mid_frame();
    int lat;
    send_byte(8'h16, 0, 18, 0);
    send_byte(8'hE0, 0, 18, 0);
    send_frame(make_frame(8'h33, 0), 6, 18, 0, lat);
    @(negedge CLK) RST_N = 1'b0;
    model_reset();
    @(negedge CLK);
    checks++;
    if ({KEY_VALID, KEY_CODE, KEY_BREAK, KEY_EXTENDED, FIFO_COUNT, FRAME_ERROR, OVERFLOW} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got %h expected 0",
               {KEY_VALID, KEY_CODE, KEY_BREAK, KEY_EXTENDED, FIFO_COUNT, FRAME_ERROR, OVERFLOW});
    end
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (20) @(negedge CLK);
    send_byte(8'h5A, 0, 18, 0);
    drain("reset_mid_next");
    check_err("reset_mid");
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      int kind, r, h;
      logic [7:0] d;
      kind = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 3));
      r = $urandom_range(0, 9);
      d = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
      h = $urandom_range(14, 30);
      send_byte(d, kind, h, 0);
      check_err("random");
      drain("random");
    end
  endtask

  initial begin
    test_reset();
    test_make_code();
    test_extended_release();
    test_parity_error();
    test_timeout();
    test_fifo();
    test_glitch();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
